// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Holds the op encoding seen on the op port, the FSM state encoding and
// the helper that sizes the iteration counter from the operand width.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Counter must be able to hold WIDTH-1 with headroom.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration.
// Ports:
//   rem      - current partial remainder (always < divisor, or divisor==0)
//   divisor  - divisor magnitude
//   in_bit   - next dividend bit, shifted in at the LSB
//   rem_next - remainder after the trial subtract
//   q_bit    - quotient bit (1 when the trial subtract did not borrow)
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             in_bit,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted  = {rem, in_bit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        // When no borrow, diff < divisor so it fits in WIDTH bits.
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// Executes MULT/MULTU (shift-add) and DIV/DIVU (restoring) in WIDTH
// iterations plus a sign-fix cycle, and MTHI/MTLO in a single cycle.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start, op    - one-cycle request and operation, sampled only in IDLE
//   a, b         - rs/rt operands (only needed on the start cycle)
//   busy         - high while an iterative op is in flight
//   done         - one-cycle pulse when hi/lo first show a new result
//   hi, lo       - HI/LO registers
//   div_by_zero  - sticky flag from DIV/DIVU with b==0, cleared on next op
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    // acc/mplier form the 2*WIDTH product register for multiply, and the
    // remainder / dividend-becoming-quotient pair for divide.
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mcand;   // multiplicand or divisor magnitude
    logic               is_div;
    logic               neg_lo;  // product sign (mul) or quotient sign (div)
    logic               neg_hi;  // remainder sign (div only)

    logic               signed_op;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic [2*WIDTH-1:0] prod;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                             input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        mul_sum   = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
        prod      = {acc, mplier};
    end

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (acc),
        .divisor  (mcand),
        .in_bit   (mplier[WIDTH-1]),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc         <= '0;
            mplier      <= '0;
            mcand       <= '0;
            is_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                mplier      <= mag(a, signed_op);
                                mcand       <= mag(b, signed_op);
                                acc         <= '0;
                                cnt         <= '0;
                                busy        <= 1'b1;
                                neg_lo      <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                                is_div      <= (op == OP_DIV) || (op == OP_DIVU);
                                neg_hi      <= (op == OP_DIV) && a[WIDTH-1];
                                div_by_zero <= ((op == OP_DIV) || (op == OP_DIVU)) && (b == '0);
                                state       <= ((op == OP_DIV) || (op == OP_DIVU)) ? S_DIV : S_MUL;
                            end
                            OP_MTHI: begin
                                hi          <= a;
                                div_by_zero <= 1'b0;
                            end
                            OP_MTLO: begin
                                lo          <= a;
                                div_by_zero <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    // Add, then shift {carry,acc,mplier} right by one.
                    acc    <= mul_sum[WIDTH:1];
                    mplier <= {mul_sum[0], mplier[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_FIX;
                end
                S_DIV: begin
                    acc    <= step_rem;
                    mplier <= {mplier[WIDTH-2:0], step_q};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_FIX;
                end
                S_FIX: begin
                    if (is_div) begin
                        // With a zero divisor the remainder equals |a| and
                        // neg_hi is a's sign, so this reproduces the original a.
                        hi <= neg_hi ? -acc : acc;
                        lo <= div_by_zero ? {WIDTH{1'b1}} : (neg_lo ? -mplier : mplier);
                    end else begin
                        {hi, lo} <= neg_lo ? -prod : prod;
                    end
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases plus a randomized mix of ops,
// compared against a plain-arithmetic reference of HI/LO behaviour.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_dbz = 1'b0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: what HI/LO/div_by_zero must hold once an op has completed.
    task automatic model_apply(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            OP_MULT: begin
                p = 64'(sx * sy);
                m_hi = p[63:32]; m_lo = p[31:0]; m_dbz = 1'b0;
            end
            OP_MULTU: begin
                p = {32'b0, x} * {32'b0, y};
                m_hi = p[63:32]; m_lo = p[31:0]; m_dbz = 1'b0;
            end
            OP_DIV, OP_DIVU: begin
                if (y == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = x; m_dbz = 1'b1;
                end else if (o == OP_DIV) begin
                    q = sx / sy;
                    r = sx % sy;
                    m_lo = 32'(q); m_hi = 32'(r); m_dbz = 1'b0;
                end else begin
                    m_lo = x / y; m_hi = x % y; m_dbz = 1'b0;
                end
            end
            OP_MTHI: begin m_hi = x; m_dbz = 1'b0; end
            OP_MTLO: begin m_lo = x; m_dbz = 1'b0; end
            default: ;
        endcase
    endtask

    // Presents a request for one cycle; returns #1 after the sampling edge T.
    task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Called in cycle T+1; follows an iterative op to IDLE checking timing.
    // inject>0 drives an MTHI request during cycle T+inject.
    task automatic finish_iter(input string tag, input int inject);
        check1({tag, ":busy_T+1"}, busy, 1'b1);
        check1({tag, ":dbz_T+1"}, div_by_zero, m_dbz);
        for (int k = 1; k <= 32; k++) begin
            if (k == inject) begin
                start = 1'b1; op = OP_MTHI; a = 32'h1234;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check1({tag, ":done_early"}, done, 1'b0);
        @(posedge clk);
        #1;
        check1({tag, ":done"}, done, 1'b1);
        check({tag, ":hi"}, hi, m_hi);
        check({tag, ":lo"}, lo, m_lo);
        check1({tag, ":dbz"}, div_by_zero, m_dbz);
        @(posedge clk);
        #1;
        check1({tag, ":done_clr"}, done, 1'b0);
        check1({tag, ":busy_clr"}, busy, 1'b0);
        check({tag, ":hi_hold"}, hi, m_hi);
    endtask

    task automatic do_iter(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        model_apply(o, x, y);
        start_op(o, x, y);
        finish_iter(tag, -1);
    endtask

    task automatic do_single(input string tag, input logic [2:0] o, input logic [31:0] x);
        model_apply(o, x, 32'd0);
        start_op(o, x, 32'd0);
        check({tag, ":hi"}, hi, m_hi);
        check({tag, ":lo"}, lo, m_lo);
        check1({tag, ":busy"}, busy, 1'b0);
        check1({tag, ":dbz"}, div_by_zero, m_dbz);
        @(posedge clk);
        #1;
        check1({tag, ":done"}, done, 1'b0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        logic        seen_done;

        // Reset values
        #2;
        check1("rst:busy", busy, 1'b0);
        check1("rst:done", done, 1'b0);
        check("rst:hi", hi, 32'd0);
        check("rst:lo", lo, 32'd0);
        check1("rst:dbz", div_by_zero, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        do_iter("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max:hi_const", hi, 32'hFFFF_FFFE);
        check("multu_max:lo_const", lo, 32'h0000_0001);

        do_iter("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3);
        check("mult_neg:hi_const", hi, 32'hFFFF_FFFF);
        check("mult_neg:lo_const", lo, 32'hFFFF_FFFA);

        do_iter("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_neg:lo_const", lo, 32'hFFFF_FFFD);
        check("div_neg:hi_const", hi, 32'hFFFF_FFFF);

        do_iter("divu_100_7", OP_DIVU, 32'd100, 32'd7);
        check("divu_100_7:lo_const", lo, 32'd14);
        check("divu_100_7:hi_const", hi, 32'd2);

        do_iter("divu_zero", OP_DIVU, 32'd7, 32'd0);
        check("divu_zero:lo_const", lo, 32'hFFFF_FFFF);
        check("divu_zero:hi_const", hi, 32'd7);
        do_single("mtlo_after_dbz", OP_MTLO, 32'd5);

        do_iter("div_neg_zero", OP_DIV, 32'hFFFF_FFF9, 32'd0);

        // Overflow case with an ignored MTHI while busy
        model_apply(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_iter("div_ovf", 10);
        check("div_ovf:lo_const", lo, 32'h8000_0000);
        check("div_ovf:hi_const", hi, 32'd0);

        // Reset in the middle of a multiply
        start_op(OP_MULT, 32'd3, 32'd5);
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check1("abort:busy", busy, 1'b0);
        check1("abort:done", done, 1'b0);
        check("abort:hi", hi, 32'd0);
        check("abort:lo", lo, 32'd0);
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            seen_done = seen_done | done | busy;
        end
        check1("abort:no_done", seen_done, 1'b0);
        do_iter("after_abort", OP_MULT, 32'd3, 32'd5);
        check("after_abort:lo_const", lo, 32'd15);

        // Randomized mix
        for (int n = 0; n < 40; n++) begin
            ro = 3'($urandom_range(0, 7));
            rx = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            case ($urandom_range(0, 4))
                0: ry = 32'd0;
                1: ry = 32'($urandom_range(1, 20));
                2: ry = -32'($urandom_range(1, 20));
                default: ry = $urandom;
            endcase
            if (ro <= OP_DIVU) begin
                do_iter("rand_iter", ro, rx, ry);
            end else if (ro <= OP_MTLO) begin
                do_single("rand_mt", ro, rx);
            end else begin
                start_op(ro, rx, ry);
                check("rand_nop:hi", hi, m_hi);
                check("rand_nop:lo", lo, m_lo);
                check1("rand_nop:busy", busy, 1'b0);
                check1("rand_nop:dbz", div_by_zero, m_dbz);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
